// File: rtl/ram_rq.sv
// ram_rq: per-client SDRAM request adapter.
//
// A rising edge on addr_ok starts one SDRAM read or write request. The
// request is held on req until the bank controller returns din_ok while
// this client is selected (we). The returned data is then latched on dout
// and data_ok is raised. A falling edge on addr_ok drops the request
// (abort) or clears data_ok after the client has consumed the data.
//
// Parameters:
//   AW - address width of addr, offset and sdram_addr
//   DW - data width of din, dout and wrdata
//
// Ports:
//   rst        - asynchronous reset, active high
//   clk        - clock, rising edge
//   addr       - client address
//   offset     - base added to addr
//   addr_ok    - client chip-select; a rising edge starts a request
//   din        - data from the SDRAM controller (read data or write echo)
//   din_ok     - din is valid
//   wrin       - sampled at request start: 1 = write, 0 = read
//   we         - arbiter has selected this client
//   req        - request pending to the SDRAM controller
//   req_rnw    - 1 = read, 0 = write
//   data_ok    - dout is valid for the current request
//   sdram_addr - addr + offset, registered at request start
//   wrdata     - din captured at request start (write payload)
//   dout       - data latched on completion
//
// Optional feature (define RAM_RQ_LFSR_EN):
//   adv        - advance the LFSR by one step this clock
//   lfsr       - 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, resets to 1

module ram_rq #(
    parameter int unsigned AW = 18,
    parameter int unsigned DW = 8
) (
    input  logic          rst,
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [AW-1:0] offset,
    input  logic          addr_ok,
    input  logic [DW-1:0] din,
    input  logic          din_ok,
    input  logic          wrin,
    input  logic          we,
`ifdef RAM_RQ_LFSR_EN
    input  logic          adv,
    output logic [15:0]   lfsr,
`endif
    output logic          req,
    output logic          req_rnw,
    output logic          data_ok,
    output logic [AW-1:0] sdram_addr,
    output logic [DW-1:0] wrdata,
    output logic [DW-1:0] dout
);

    logic last_cs;
    logic cs_pos;
    logic cs_neg;

    assign cs_pos = addr_ok & ~last_cs;
    assign cs_neg = ~addr_ok & last_cs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_cs    <= 1'b0;
            req        <= 1'b0;
            req_rnw    <= 1'b1;
            data_ok    <= 1'b0;
            sdram_addr <= '0;
            wrdata     <= '0;
            dout       <= '0;
        end else begin
            last_cs <= addr_ok;
            // While selected, completion owns the outputs; any chip-select
            // edge seen in the same cycle is dropped.
            if (we) begin
                if (din_ok) begin
                    req     <= 1'b0;
                    data_ok <= 1'b1;
                    dout    <= din;
                end
            end else if (cs_pos) begin
                req        <= 1'b1;
                req_rnw    <= ~wrin;
                data_ok    <= 1'b0;
                sdram_addr <= addr + offset;  // carry out of AW bits dropped
                wrdata     <= din;
            end else if (cs_neg) begin
                req     <= 1'b0;
                data_ok <= 1'b0;
            end
        end
    end

`ifdef RAM_RQ_LFSR_EN
    // Taps 16,14,13,11 give a maximal-length sequence; the all-zero state
    // is unreachable from the non-zero reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'h0001;
        end else if (adv) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end
`endif

endmodule

// File: tb/tb_ram_rq.sv
module tb_ram_rq;

    localparam int unsigned AW = 22;
    localparam int unsigned DW = 16;

    logic          rst;
    logic          clk;
    logic [AW-1:0] addr;
    logic [AW-1:0] offset;
    logic          addr_ok;
    logic [DW-1:0] din;
    logic          din_ok;
    logic          wrin;
    logic          we;
    logic          adv;
    logic [15:0]   lfsr;
    logic          req;
    logic          req_rnw;
    logic          data_ok;
    logic [AW-1:0] sdram_addr;
    logic [DW-1:0] wrdata;
    logic [DW-1:0] dout;

    int n_cmp;
    int n_bad;
    int req_rises;
    logic req_prev;

    ram_rq #(.AW(AW), .DW(DW)) dut (
        .rst        (rst),
        .clk        (clk),
        .addr       (addr),
        .offset     (offset),
        .addr_ok    (addr_ok),
        .din        (din),
        .din_ok     (din_ok),
        .wrin       (wrin),
        .we         (we),
`ifdef RAM_RQ_LFSR_EN
        .adv        (adv),
        .lfsr       (lfsr),
`endif
        .req        (req),
        .req_rnw    (req_rnw),
        .data_ok    (data_ok),
        .sdram_addr (sdram_addr),
        .wrdata     (wrdata),
        .dout       (dout)
    );

`ifndef RAM_RQ_LFSR_EN
    assign lfsr = 16'h0000;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges of req, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            req_prev <= 1'b0;
        end else begin
            if (req && !req_prev) req_rises <= req_rises + 1;
            req_prev <= req;
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] offset;
        logic          addr_ok;
        logic          wrin;
        logic [DW-1:0] din;
        logic          din_ok;
        logic          we;
        logic          e_req;
        logic          e_rnw;
        logic          e_dok;
        logic [AW-1:0] e_sa;
        logic [DW-1:0] e_wd;
        logic [DW-1:0] e_dout;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic e_req, input logic e_rnw,
                             input logic e_dok, input logic [AW-1:0] e_sa,
                             input logic [DW-1:0] e_wd, input logic [DW-1:0] e_dout);
        check({tag, ".req"}, 32'(req), 32'(e_req));
        check({tag, ".req_rnw"}, 32'(req_rnw), 32'(e_rnw));
        check({tag, ".data_ok"}, 32'(data_ok), 32'(e_dok));
        check({tag, ".sdram_addr"}, 32'(sdram_addr), 32'(e_sa));
        check({tag, ".wrdata"}, 32'(wrdata), 32'(e_wd));
        check({tag, ".dout"}, 32'(dout), 32'(e_dout));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        req_rises = 0;
        rst = 1'b1;
        addr = '0; offset = '0; addr_ok = 1'b0; din = '0;
        din_ok = 1'b0; wrin = 1'b0; we = 1'b0; adv = 1'b0;

        //        addr      off  ok wr din      dok we | req rnw dok sa        wd       dout
        vecs[0]  = '{22'h123,    0, 1, 0, 16'h0000, 0, 0, 1, 1, 0, 22'h123,    16'h0000, 16'h0000};
        vecs[1]  = '{22'h200,    0, 1, 0, 16'h0000, 0, 0, 1, 1, 0, 22'h123,    16'h0000, 16'h0000};
        vecs[2]  = '{22'h200,    0, 1, 0, 16'hBEEF, 1, 1, 0, 1, 1, 22'h123,    16'h0000, 16'hBEEF};
        vecs[3]  = '{22'h200,    0, 1, 0, 16'h0000, 0, 0, 0, 1, 1, 22'h123,    16'h0000, 16'hBEEF};
        vecs[4]  = '{22'h200,    0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 22'h123,    16'h0000, 16'hBEEF};
        vecs[5]  = '{22'h040,    0, 1, 1, 16'h5A5A, 0, 0, 1, 0, 0, 22'h040,    16'h5A5A, 16'hBEEF};
        vecs[6]  = '{22'h040,    0, 1, 0, 16'h5A5A, 1, 1, 0, 0, 1, 22'h040,    16'h5A5A, 16'h5A5A};
        vecs[7]  = '{22'h040,    0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 22'h040,    16'h5A5A, 16'h5A5A};
        vecs[8]  = '{22'h3FFFFF, 2, 1, 0, 16'h0000, 0, 0, 1, 1, 0, 22'h000001, 16'h0000, 16'h5A5A};
        vecs[9]  = '{22'h3FFFFF, 2, 1, 0, 16'h1111, 1, 0, 1, 1, 0, 22'h000001, 16'h0000, 16'h5A5A};
        vecs[10] = '{22'h3FFFFF, 2, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 22'h000001, 16'h0000, 16'h5A5A};
        vecs[11] = '{22'h010,    0, 1, 0, 16'h0000, 0, 0, 1, 1, 0, 22'h010,    16'h0000, 16'h5A5A};
        vecs[12] = '{22'h010,    0, 1, 0, 16'h0077, 1, 1, 0, 1, 1, 22'h010,    16'h0000, 16'h0077};
        vecs[13] = '{22'h010,    0, 0, 0, 16'h0000, 0, 1, 0, 1, 1, 22'h010,    16'h0000, 16'h0077};
        vecs[14] = '{22'h010,    0, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 22'h010,    16'h0000, 16'h0077};
        vecs[15] = '{22'h020,    5, 1, 1, 16'hABCD, 0, 0, 1, 0, 0, 22'h025,    16'hABCD, 16'h0077};
        vecs[16] = '{22'h020,    5, 1, 0, 16'h0000, 0, 1, 1, 0, 0, 22'h025,    16'hABCD, 16'h0077};

        repeat (2) @(negedge clk);
        check_all("reset", 1'b0, 1'b1, 1'b0, '0, '0, '0);
        rst = 1'b0;
        check("reset.lfsr", 32'(lfsr), 32'(
`ifdef RAM_RQ_LFSR_EN
            16'h0001
`else
            16'h0000
`endif
        ));

        for (int i = 0; i < 17; i++) begin
            addr    = vecs[i].addr;
            offset  = vecs[i].offset;
            addr_ok = vecs[i].addr_ok;
            wrin    = vecs[i].wrin;
            din     = vecs[i].din;
            din_ok  = vecs[i].din_ok;
            we      = vecs[i].we;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_rnw, vecs[i].e_dok,
                      vecs[i].e_sa, vecs[i].e_wd, vecs[i].e_dout);
        end

        // Asynchronous reset mid-request: outputs clear without a clock edge.
        we = 1'b0; din_ok = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all("async_rst", 1'b0, 1'b1, 1'b0, '0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        addr_ok = 1'b0; wrin = 1'b0; offset = '0; din = '0;
        step();

        // Sweep: one request per address, controller echoes the address.
        req_rises = 0;
        for (int a = 0; a < 256; a++) begin
            addr = AW'(a); addr_ok = 1'b1;
            step();
            check($sformatf("sweep%0d.req", a), 32'(req), 32'd1);
            check($sformatf("sweep%0d.sa", a), 32'(sdram_addr), 32'(a));
            step();
            check($sformatf("sweep%0d.hold", a), 32'(req), 32'd1);
            we = 1'b1; din_ok = 1'b1; din = DW'(a);
            step();
            we = 1'b0; din_ok = 1'b0;
            check($sformatf("sweep%0d.dok", a), 32'(data_ok), 32'd1);
            check($sformatf("sweep%0d.dout", a), 32'(dout), 32'(a));
            check($sformatf("sweep%0d.req_clr", a), 32'(req), 32'd0);
            addr_ok = 1'b0;
            step();
            check($sformatf("sweep%0d.clr", a), 32'(data_ok), 32'd0);
        end
        @(negedge clk);
        check("sweep.req_rises", 32'(req_rises), 32'd256);

`ifdef RAM_RQ_LFSR_EN
        begin
            int n;
            int zero_seen;
            int early;
            logic [15:0] held;
            adv = 1'b1;
            step();
            check("lfsr.first", 32'(lfsr), 32'h0002);
            n = 1;
            zero_seen = 0;
            early = 0;
            while (n < 65535) begin
                step();
                n++;
                if (lfsr == 16'h0000) zero_seen++;
                if (lfsr == 16'h0001 && n < 65535) early++;
            end
            check("lfsr.period", 32'(lfsr), 32'h0001);
            check("lfsr.no_zero", 32'(zero_seen), 32'd0);
            check("lfsr.no_early", 32'(early), 32'd0);
            step();
            adv = 1'b0;
            held = lfsr;
            check("lfsr.step_after_wrap", 32'(held), 32'h0002);
            repeat (3) step();
            check("lfsr.hold", 32'(lfsr), 32'h0002);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
